// File: rtl/rgbw_spi_pkg.sv
// Shared definitions for the RGBW lamp SPI link: master FSM states and the
// byte positions inside a lamp command frame.
package rgbw_spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StShift,
    StNext,
    StTrail,
    StGap
  } spi_state_e;

  // Byte positions within a lamp command frame, shared with receiver and dispenser.
  localparam int unsigned MODE      = 0;
  localparam int unsigned LINT      = 1;
  localparam int unsigned COLOR_IDX = 2;
  localparam int unsigned WHITE     = 3;
  localparam int unsigned RED       = 4;
  localparam int unsigned GREEN     = 5;
  localparam int unsigned BLUE      = 6;
  localparam int unsigned FRAME_LEN = 7;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: ticks every CLK_DIV enabled cycles and
// toggles sck on each tick while sck_en is high.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sck_en,
  output logic tick,
  output logic rise,
  output logic fall,
  output logic sck
);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;

  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));
  assign rise = tick && sck_en && !sck_q;
  assign fall = tick && sck_en && sck_q;
  assign sck  = sck_q;

  always_comb begin
    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + 8'd1;
    sck_d = 1'b0;
    if (sck_en) sck_d = tick ? !sck_q : sck_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/rgbw_spi_master.sv
// SPI mode-0 master for RGBW lamp frames: double-buffered byte stream in,
// MSB-first sck/mosi with cs framing and a minimum inter-frame gap out.
module rgbw_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       sck,
  output logic       mosi,
  output logic       cs,
  output logic       busy,
  output logic       frame_done,
  output logic [3:0] byte_cnt
);
  import rgbw_spi_pkg::*;

  spi_state_e state_q, state_d;
  logic [7:0] hold_q, hold_d, shift_q, shift_d, gap_q, gap_d;
  logic       hold_last_q, hold_last_d, hold_full_q, hold_full_d;
  logic       shift_last_q, shift_last_d;
  logic [3:0] bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d;
  logic       cs_q, cs_d, mosi_q, mosi_d, frame_done_q, frame_done_d;
  logic       accept, load, clk_en, sck_en, tick, rise, fall;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en),
    .sck_en(sck_en),
    .tick  (tick),
    .rise  (rise),
    .fall  (fall),
    .sck   (sck)
  );

  always_comb begin
    accept       = tx_valid && !hold_full_q;
    state_d      = state_q;
    hold_d       = accept ? tx_data : hold_q;
    hold_last_d  = accept ? tx_last : hold_last_q;
    hold_full_d  = hold_full_q | accept;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    gap_d        = '0;
    cs_d         = cs_q;
    mosi_d       = mosi_q;
    frame_done_d = 1'b0;
    clk_en       = 1'b0;
    sck_en       = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          load       = 1'b1;
          cs_d       = 1'b0;
          byte_cnt_d = '0;
          state_d    = StLead;
        end
      end
      StLead: begin
        clk_en = 1'b1;
        if (tick) state_d = StShift;
      end
      StShift: begin
        clk_en = 1'b1;
        sck_en = 1'b1;
        if (rise) bit_cnt_d = bit_cnt_q + 4'd1;
        if (fall) begin
          shift_d = {shift_q[6:0], 1'b0};
          mosi_d  = shift_q[6];
          // Falling edge after the 8th rise closes the byte.
          if (bit_cnt_q == 4'd8) begin
            byte_cnt_d = (byte_cnt_q == 4'hF) ? byte_cnt_q : byte_cnt_q + 4'd1;
            if (shift_last_q)     state_d = StTrail;
            else if (hold_full_q) load = 1'b1;
            else                  state_d = StNext;
          end
        end
      end
      StNext: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StTrail: begin
        clk_en = 1'b1;
        if (tick) begin
          cs_d         = 1'b1;
          frame_done_d = 1'b1;
          state_d      = StGap;
        end
      end
      StGap: begin
        if (gap_q == 8'(CS_GAP - 1)) state_d = StIdle;
        else                         gap_d = gap_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase

    // Hold -> shift transfer; the next accept can only land a cycle later.
    if (load) begin
      shift_d      = hold_q;
      shift_last_d = hold_last_q;
      hold_full_d  = 1'b0;
      mosi_d       = hold_q[7];
      bit_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      gap_q        <= '0;
      cs_q         <= 1'b1;
      mosi_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_q        <= gap_d;
      cs_q         <= cs_d;
      mosi_q       <= mosi_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_ready   = !hold_full_q;
  assign cs         = cs_q;
  assign mosi       = mosi_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_rgbw_spi_master.sv
// Bench for rgbw_spi_master: two instances (CLK_DIV=4 and CLK_DIV=1) driven by directed
// and random frames, checked by a pin-level SPI receiver model.
module tb_rgbw_spi_master;

  localparam int unsigned D0 = 4;
  localparam int unsigned G0 = 8;
  localparam int unsigned D1 = 1;
  localparam int unsigned G1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data_w [2];
  logic       tx_valid_w [2];
  logic       tx_last_w [2];
  logic       tx_ready_w [2];
  logic       sck_w [2];
  logic       mosi_w [2];
  logic       cs_w [2];
  logic       busy_w [2];
  logic       frame_done_w [2];
  logic [3:0] byte_cnt_w [2];

  always #5 clk = ~clk;

  rgbw_spi_master #(.CLK_DIV(D0), .CS_GAP(G0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_w[0]), .tx_valid(tx_valid_w[0]),
    .tx_last(tx_last_w[0]), .tx_ready(tx_ready_w[0]), .sck(sck_w[0]), .mosi(mosi_w[0]),
    .cs(cs_w[0]), .busy(busy_w[0]), .frame_done(frame_done_w[0]), .byte_cnt(byte_cnt_w[0])
  );

  rgbw_spi_master #(.CLK_DIV(D1), .CS_GAP(G1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_w[1]), .tx_valid(tx_valid_w[1]),
    .tx_last(tx_last_w[1]), .tx_ready(tx_ready_w[1]), .sck(sck_w[1]), .mosi(mosi_w[1]),
    .cs(cs_w[1]), .busy(busy_w[1]), .frame_done(frame_done_w[1]), .byte_cnt(byte_cnt_w[1])
  );

  // Receiver model state, owned by the monitor process.
  logic [7:0] cap_mem [2][256];
  int         win_mem [2][256];
  logic [7:0] acc [2];
  int cap_n [2]   = '{0, 0};
  int bits [2]    = '{0, 0};
  int lo_cnt [2]  = '{0, 0};
  int hi_cnt [2]  = '{0, 0};
  int hi_last [2] = '{0, 0};
  int win_n [2]   = '{0, 0};
  int fd_n [2]    = '{0, 0};
  int viol [2]    = '{0, 0};
  int rise_n [2]  = '{0, 0};
  logic sck_p [2] = '{1'b0, 1'b0};
  logic cs_p [2]  = '{1'b1, 1'b1};

  // Bench-side expectation state.
  logic [7:0] sent_mem [2][256];
  int sent_n [2]   = '{0, 0};
  int done_idx [2] = '{0, 0};
  int n_tests = 0;
  int n_fail  = 0;
  int fd0, w0, r0, t, n, dk;
  bit kk, stall;
  logic [7:0] frame7 [7] = '{8'h01, 8'h80, 8'h10, 8'hFF, 8'h00, 8'h7F, 8'hC3};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      sck_p[1'(k)] <= sck_w[1'(k)];
      cs_p[1'(k)]  <= cs_w[1'(k)];
      if (frame_done_w[1'(k)]) fd_n[1'(k)] <= fd_n[1'(k)] + 1;
      if (cs_w[1'(k)] && sck_w[1'(k)]) viol[1'(k)] <= viol[1'(k)] + 1;
      if (cs_w[1'(k)]) begin
        bits[1'(k)]   <= 0;
        hi_cnt[1'(k)] <= hi_cnt[1'(k)] + 1;
        lo_cnt[1'(k)] <= 0;
        if (!cs_p[1'(k)]) begin
          win_mem[1'(k)][8'(win_n[1'(k)])] <= lo_cnt[1'(k)];
          win_n[1'(k)] <= win_n[1'(k)] + 1;
        end
      end else begin
        lo_cnt[1'(k)] <= lo_cnt[1'(k)] + 1;
        hi_cnt[1'(k)] <= 0;
        if (cs_p[1'(k)]) hi_last[1'(k)] <= hi_cnt[1'(k)];
        if (sck_w[1'(k)] && !sck_p[1'(k)]) begin
          rise_n[1'(k)] <= rise_n[1'(k)] + 1;
          acc[1'(k)]    <= {acc[1'(k)][6:0], mosi_w[1'(k)]};
          if (bits[1'(k)] == 7) begin
            cap_mem[1'(k)][8'(cap_n[1'(k)])] <= {acc[1'(k)][6:0], mosi_w[1'(k)]};
            cap_n[1'(k)] <= cap_n[1'(k)] + 1;
            bits[1'(k)]  <= 0;
          end else begin
            bits[1'(k)] <= bits[1'(k)] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Offer one byte and return on the negedge after it is accepted; tx_valid stays high.
  task automatic send(input bit k, input logic [7:0] d, input logic l, input bit rec);
    int w;
    w = 0;
    tx_data_w[k]  = d;
    tx_last_w[k]  = l;
    tx_valid_w[k] = 1'b1;
    while (tx_ready_w[k] !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    chk_rng("accept_wait", w, 0, 3999);
    if (rec) begin
      sent_mem[k][8'(sent_n[k])] = d;
      sent_n[k]++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit k);
    tx_valid_w[k] = 1'b0;
    tx_last_w[k]  = 1'b0;
  endtask

  task automatic wait_fd(input bit k, input int target);
    int w;
    w = 0;
    while (fd_n[k] < target && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk_rng("frame_wait", w, 0, 19999);
    repeat (2) @(negedge clk);
  endtask

  task automatic cmp_bytes(input bit k);
    chk("byte_count", cap_n[k], sent_n[k]);
    for (int i = done_idx[k]; i < sent_n[k]; i++) chk("byte", cap_mem[k][8'(i)], sent_mem[k][8'(i)]);
    done_idx[k] = sent_n[k];
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      tx_data_w[1'(k)]  = '0;
      tx_valid_w[1'(k)] = 1'b0;
      tx_last_w[1'(k)]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_cs", cs_w[0], 1);
    chk("rst_sck", sck_w[0], 0);
    chk("rst_mosi", mosi_w[0], 0);
    chk("rst_ready", tx_ready_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_fd", frame_done_w[0], 0);
    chk("rst_cnt", byte_cnt_w[0], 0);
    chk("rst_cs1", cs_w[1], 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 with latency checks.
    fd0 = fd_n[0];
    tx_data_w[0] = 8'hA5; tx_last_w[0] = 1'b1; tx_valid_w[0] = 1'b1;
    sent_mem[0][8'(sent_n[0])] = 8'hA5; sent_n[0]++;
    @(negedge clk);
    chk("t1_cs_before", cs_w[0], 1);
    chk("t1_ready_full", tx_ready_w[0], 0);
    idle(0);
    @(negedge clk);
    chk("t1_cs_fall", cs_w[0], 0);
    chk("t1_busy", busy_w[0], 1);
    wait_fd(0, fd0 + 1);
    chk("t1_fd_once", fd_n[0], fd0 + 1);
    chk("t1_byte_cnt", byte_cnt_w[0], 1);
    chk_rng("t1_cs_low", win_mem[0][8'(win_n[0] - 1)], 18 * D0 - 1, 18 * D0 + 1);
    chk("t1_busy_gap", busy_w[0], 1);
    cmp_bytes(0);
    repeat (G0 + 2) @(negedge clk);
    chk("t1_busy_idle", busy_w[0], 0);

    // Seven-byte frame streamed with tx_valid held high.
    fd0 = fd_n[0]; w0 = win_n[0];
    for (int i = 0; i < 7; i++) send(0, frame7[i], i == 6, 1);
    idle(0);
    wait_fd(0, fd0 + 1);
    chk("t2_byte_cnt", byte_cnt_w[0], 7);
    chk("t2_one_window", win_n[0], w0 + 1);
    chk_rng("t2_cs_low", win_mem[0][8'(win_n[0] - 1)], (16 * 7 + 2) * D0 - 1,
            (16 * 7 + 2) * D0 + 1);
    cmp_bytes(0);
    repeat (G0 + 4) @(negedge clk);

    // Underrun stall between two bytes.
    fd0 = fd_n[0];
    send(0, 8'h11, 1'b0, 1);
    idle(0);
    repeat (100) @(negedge clk);
    chk("t3_stall_cs", cs_w[0], 0);
    chk("t3_stall_sck", sck_w[0], 0);
    chk("t3_stall_busy", busy_w[0], 1);
    repeat (37) @(negedge clk);
    chk("t3_stall_sck2", sck_w[0], 0);
    send(0, 8'h22, 1'b1, 1);
    idle(0);
    wait_fd(0, fd0 + 1);
    chk("t3_byte_cnt", byte_cnt_w[0], 2);
    cmp_bytes(0);
    repeat (G0 + 4) @(negedge clk);

    // Back-to-back frames: B0 waits in hold through A's trailer, C offered during GAP.
    fd0 = fd_n[0];
    send(0, 8'($urandom), 1'b0, 1);
    send(0, 8'($urandom), 1'b1, 1);
    send(0, 8'($urandom), 1'b0, 1);
    send(0, 8'($urandom), 1'b1, 1);
    idle(0);
    chk("t4_b_cs", cs_w[0], 0);
    chk("t4_cnt_restart", byte_cnt_w[0], 0);
    wait_fd(0, fd0 + 2);
    chk_rng("t4_gap_ab", hi_last[0], G0, G0 + 1);
    chk("t4_fd_two", fd_n[0], fd0 + 2);
    send(0, 8'h6B, 1'b1, 1);
    idle(0);
    wait_fd(0, fd0 + 3);
    chk_rng("t4_gap_bc", hi_last[0], G0, G0 + 1);
    chk("t4_byte_cnt", byte_cnt_w[0], 1);
    cmp_bytes(0);
    repeat (G0 + 4) @(negedge clk);

    // Asynchronous reset mid-byte with a second byte already held.
    r0 = rise_n[0];
    send(0, 8'h3C, 1'b0, 0);
    send(0, 8'h99, 1'b0, 0);
    idle(0);
    t = 0;
    while (rise_n[0] < r0 + 4 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk_rng("t5_rise_wait", t, 0, 1999);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cs", cs_w[0], 1);
    chk("t5_sck", sck_w[0], 0);
    chk("t5_mosi", mosi_w[0], 0);
    chk("t5_ready", tx_ready_w[0], 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fd0 = fd_n[0];
    send(0, 8'h55, 1'b1, 1);
    idle(0);
    wait_fd(0, fd0 + 1);
    chk("t5_byte_cnt", byte_cnt_w[0], 1);
    cmp_bytes(0);
    repeat (G0 + 4) @(negedge clk);

    // CLK_DIV=1 instance.
    fd0 = fd_n[1];
    send(1, 8'hF0, 1'b1, 1);
    idle(1);
    wait_fd(1, fd0 + 1);
    chk_rng("t6_cs_low", win_mem[1][8'(win_n[1] - 1)], 18 * D1 - 1, 18 * D1 + 1);
    chk("t6_byte_cnt", byte_cnt_w[1], 1);
    cmp_bytes(1);
    repeat (G1 + 4) @(negedge clk);

    // byte_cnt saturation on a 17-byte frame.
    fd0 = fd_n[1];
    for (int i = 0; i < 17; i++) send(1, 8'($urandom), i == 16, 1);
    idle(1);
    wait_fd(1, fd0 + 1);
    chk("t7_byte_cnt_sat", byte_cnt_w[1], 15);
    chk_rng("t7_cs_low", win_mem[1][8'(win_n[1] - 1)], (16 * 17 + 2) * D1 - 1,
            (16 * 17 + 2) * D1 + 1);
    cmp_bytes(1);
    repeat (G1 + 4) @(negedge clk);

    // Random frames on either instance, with optional inter-byte stalls.
    for (int f = 0; f < 8; f++) begin
      kk    = 1'($urandom_range(0, 1));
      n     = $urandom_range(1, 8);
      stall = ($urandom_range(0, 2) == 0);
      dk    = kk ? D1 : D0;
      fd0   = fd_n[kk];
      for (int i = 0; i < n; i++) begin
        if (stall && i > 0) begin
          idle(kk);
          repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        send(kk, 8'($urandom), i == n - 1, 1);
      end
      idle(kk);
      wait_fd(kk, fd0 + 1);
      chk("rnd_fd", fd_n[kk], fd0 + 1);
      chk("rnd_byte_cnt", byte_cnt_w[kk], n);
      if (!stall)
        chk_rng("rnd_cs_low", win_mem[kk][8'(win_n[kk] - 1)], (16 * n + 2) * dk - 1,
                (16 * n + 2) * dk + 1);
      cmp_bytes(kk);
      repeat (G0 + 4) @(negedge clk);
    end

    chk("sck_idle_0", viol[0], 0);
    chk("sck_idle_1", viol[1], 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
